// File: rtl/contador_programa_contexto_if.sv
// Fetch/control bundle between the program-counter sequencer and its environment.
// master drives the control inputs; slave is the sequencer.
interface contador_programa_contexto_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  stall;
    logic                  desvio;
    logic [ADDR_WIDTH-1:0] alvo;
    logic                  retorno;
    logic                  troca_req;
    logic [3:0]            proc_sel;
    logic                  halt_proc;
    logic [ADDR_WIDTH-1:0] endereco;
    logic [3:0]            slot_atual;
    logic                  em_usuario;
    logic                  preempcao;
    logic                  erro;

    modport master (
        output stall, desvio, alvo, retorno, troca_req, proc_sel, halt_proc,
        input  endereco, slot_atual, em_usuario, preempcao, erro
    );

    modport slave (
        input  stall, desvio, alvo, retorno, troca_req, proc_sel, halt_proc,
        output endereco, slot_atual, em_usuario, preempcao, erro
    );
endinterface

// File: rtl/contador_programa_contexto.sv
// Slot-relative PC sequencer with context switch and per-slot saved-PC table.
// Define PREEMPCAO_EN to build the quantum counter and time-slice preemption.
module contador_programa_contexto #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SLOT_SIZE  = 200,
    parameter int unsigned NUM_SLOTS  = 10,
    parameter int unsigned QUANTUM    = 64
) (
    input  logic                          clock,
    input  logic                          reset_n,
    contador_programa_contexto_if.slave   bus
);
    localparam int unsigned PC_W = (SLOT_SIZE > 1) ? $clog2(SLOT_SIZE) : 1;

    typedef enum logic [1:0] {
        ST_SO    = 2'd0,
        ST_TROCA = 2'd1,
        ST_USER  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [3:0]            slot_q, slot_d;
    logic [ADDR_WIDTH-1:0] endereco_q, endereco_d;
    logic                  em_usuario_q, em_usuario_d;
    logic                  preempcao_q, preempcao_d;
    logic                  erro_q, erro_d;
    logic [PC_W-1:0]       tbl_q [NUM_SLOTS];

    logic                  tbl_we;
    logic [3:0]            tbl_idx;
    logic [PC_W-1:0]       tbl_wdata;
    logic                  cnt_load, cnt_dec;
    logic                  expira_c;
    logic                  sel_ok_c, alvo_ok_c;
    logic [PC_W-1:0]       pc_step_c, pc_alvo_c;

    assign sel_ok_c  = (bus.proc_sel >= 4'd2) && (32'(bus.proc_sel) < NUM_SLOTS);
    assign alvo_ok_c = bus.alvo < ADDR_WIDTH'(SLOT_SIZE);
    assign pc_alvo_c = alvo_ok_c ? PC_W'(bus.alvo) : '0;
    assign pc_step_c = (pc_q == PC_W'(SLOT_SIZE - 1)) ? '0 : pc_q + PC_W'(1);

`ifdef PREEMPCAO_EN
    localparam int unsigned CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expira_c = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_load)     cnt_d = CNT_W'(QUANTUM - 1);
        else if (cnt_dec) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    localparam int unsigned unused_quantum = QUANTUM;
    logic unused_cnt;
    assign unused_cnt = cnt_load ^ cnt_dec;
    assign expira_c   = 1'b0;
`endif

    // Next-state, table update and registered-output computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        slot_d      = slot_q;
        erro_d      = 1'b0;
        preempcao_d = 1'b0;
        tbl_we      = 1'b0;
        tbl_idx     = slot_q;
        tbl_wdata   = '0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        if (!bus.stall) begin
            case (state_q)
                ST_SO: begin
                    if (bus.troca_req && sel_ok_c) begin
                        state_d  = ST_USER;
                        slot_d   = bus.proc_sel;
                        pc_d     = tbl_q[bus.proc_sel];
                        cnt_load = 1'b1;
                    end else if (bus.troca_req) begin
                        erro_d = 1'b1;
                        pc_d   = pc_step_c;
                    end else if (bus.desvio) begin
                        pc_d   = pc_alvo_c;
                        erro_d = !alvo_ok_c;
                    end else begin
                        pc_d = pc_step_c;
                    end
                end
                ST_TROCA: begin
                    if (bus.retorno) begin
                        state_d = ST_SO;
                        slot_d  = 4'd1;
                        pc_d    = '0;
                    end else if (bus.desvio) begin
                        pc_d   = pc_alvo_c;
                        erro_d = !alvo_ok_c;
                    end else begin
                        pc_d = pc_step_c;
                    end
                end
                ST_USER: begin
                    if (bus.halt_proc) begin
                        tbl_we  = 1'b1;
                        state_d = ST_TROCA;
                        slot_d  = 4'd0;
                        pc_d    = '0;
                    end else if (expira_c) begin
                        // Save where the program would have continued.
                        preempcao_d = 1'b1;
                        tbl_we      = 1'b1;
                        tbl_wdata   = bus.desvio ? pc_alvo_c : pc_step_c;
                        erro_d      = bus.desvio && !alvo_ok_c;
                        state_d     = ST_TROCA;
                        slot_d      = 4'd0;
                        pc_d        = '0;
                    end else if (bus.desvio) begin
                        pc_d    = pc_alvo_c;
                        erro_d  = !alvo_ok_c;
                        cnt_dec = 1'b1;
                    end else begin
                        pc_d    = pc_step_c;
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_SO;
                    slot_d  = 4'd1;
                    pc_d    = '0;
                end
            endcase
        end

        em_usuario_d = (state_d == ST_USER);
        endereco_d   = ADDR_WIDTH'(slot_d) * ADDR_WIDTH'(SLOT_SIZE) + ADDR_WIDTH'(pc_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SO;
            pc_q         <= '0;
            slot_q       <= 4'd1;
            endereco_q   <= ADDR_WIDTH'(SLOT_SIZE);
            em_usuario_q <= 1'b0;
            preempcao_q  <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            slot_q       <= slot_d;
            endereco_q   <= endereco_d;
            em_usuario_q <= em_usuario_d;
            preempcao_q  <= preempcao_d;
            erro_q       <= erro_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) tbl_q[i] <= '0;
        end else if (tbl_we) begin
            tbl_q[tbl_idx] <= tbl_wdata;
        end
    end

    assign bus.endereco   = endereco_q;
    assign bus.slot_atual = slot_q;
    assign bus.em_usuario = em_usuario_q;
    assign bus.preempcao  = preempcao_q;
    assign bus.erro       = erro_q;
endmodule

// File: tb/tb_contador_programa_contexto.sv
// Randomized and directed bench for contador_programa_contexto (QUANTUM=4),
// checked against a slot/PC reference model; follows the PREEMPCAO_EN build.
module tb_contador_programa_contexto;
    localparam int AW = 32;
    localparam int SS = 200;
    localparam int NS = 10;
    localparam int QT = 4;

`ifdef PREEMPCAO_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    contador_programa_contexto_if #(.ADDR_WIDTH(AW)) bus ();

    contador_programa_contexto #(
        .ADDR_WIDTH(AW), .SLOT_SIZE(SS), .NUM_SLOTS(NS), .QUANTUM(QT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Reference model: slot 0 = context-switch routine, 1 = OS, >=2 = user.
    int m_slot, m_pc, m_left;
    int m_tbl [NS];
    bit m_pre, m_err;

    function automatic int exp_addr();
        return m_slot * SS + m_pc;
    endfunction

    task automatic model_reset();
        m_slot = 1; m_pc = 0; m_left = 0; m_pre = 0; m_err = 0;
        for (int i = 0; i < NS; i++) m_tbl[i] = 0;
    endtask

    task automatic model_branch();
        if (int'(bus.alvo) >= SS || bus.alvo[AW-1]) begin
            m_pc = 0; m_err = 1;
        end else m_pc = int'(bus.alvo);
    endtask

    task automatic model_step();
        m_pre = 0; m_err = 0;
        if (bus.stall) return;
        if (m_slot == 1) begin
            if (bus.troca_req && bus.proc_sel >= 2 && int'(bus.proc_sel) < NS) begin
                m_slot = int'(bus.proc_sel); m_pc = m_tbl[m_slot]; m_left = QT;
            end else if (bus.troca_req) begin
                m_err = 1; m_pc = (m_pc + 1) % SS;
            end else if (bus.desvio) model_branch();
            else m_pc = (m_pc + 1) % SS;
        end else if (m_slot == 0) begin
            if (bus.retorno) begin m_slot = 1; m_pc = 0; end
            else if (bus.desvio) model_branch();
            else m_pc = (m_pc + 1) % SS;
        end else begin
            if (bus.halt_proc) begin
                m_tbl[m_slot] = 0; m_slot = 0; m_pc = 0;
            end else if (PREEMPT && m_left == 1) begin
                m_pre = 1;
                m_tbl[m_slot] = bus.desvio ? int'(bus.alvo) : (m_pc + 1) % SS;
                m_slot = 0; m_pc = 0;
            end else begin
                if (bus.desvio) model_branch();
                else m_pc = (m_pc + 1) % SS;
                m_left--;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.desvio = 0; bus.alvo = '0; bus.retorno = 0;
        bus.troca_req = 0; bus.proc_sel = 4'd0; bus.halt_proc = 0;
    endtask

    // Advance model with the current inputs, clock once, land #1 after the edge.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    task automatic go_so();
        for (int i = 0; i < 8 && m_slot != 1; i++) begin
            if (m_slot >= 2) bus.halt_proc = 1;
            else bus.retorno = 1;
            tick();
        end
    endtask

    task automatic dispatch(input int sel);
        bus.troca_req = 1; bus.proc_sel = 4'(sel);
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (bus.endereco !== 32'd200) begin n_fail++; $display("FAIL reset_endereco: got %0d expected 200", bus.endereco); end
        n_checks++; if (bus.slot_atual !== 4'd1) begin n_fail++; $display("FAIL reset_slot: got %0d expected 1", bus.slot_atual); end
        n_checks++; if (bus.em_usuario !== 1'b0) begin n_fail++; $display("FAIL reset_em_usuario: got %b expected 0", bus.em_usuario); end
        n_checks++; if ({bus.preempcao, bus.erro} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {bus.preempcao, bus.erro}); end
        reset_n = 1;
    endtask

    task automatic test_wrap();
        repeat (199) tick();
        n_checks++; if (bus.endereco !== 32'd399) begin n_fail++; $display("FAIL wrap_199: got %0d expected 399", bus.endereco); end
        tick();
        n_checks++; if (bus.endereco !== 32'd200) begin n_fail++; $display("FAIL wrap_200: got %0d expected 200", bus.endereco); end
    endtask

    task automatic test_dispatch();
        int exp_seq [4] = '{400, 401, 402, 403};
        dispatch(2);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.endereco !== 32'(exp_seq[k]) || bus.em_usuario !== 1'b1) begin
                n_fail++; $display("FAIL dispatch_seq%0d: got %0d/%b expected %0d/1", k, bus.endereco, bus.em_usuario, exp_seq[k]);
            end
            if (k < 3) tick();
        end
        tick();
        if (PREEMPT) begin
            n_checks++; if (bus.endereco !== 32'd0 || bus.preempcao !== 1'b1) begin
                n_fail++; $display("FAIL quantum_expiry: got %0d pre=%b expected 0 pre=1", bus.endereco, bus.preempcao);
            end
        end else begin
            n_checks++; if (bus.endereco !== 32'd404 || bus.preempcao !== 1'b0) begin
                n_fail++; $display("FAIL no_expiry: got %0d pre=%b expected 404 pre=0", bus.endereco, bus.preempcao);
            end
            bus.halt_proc = 1; tick();
        end
        tick();
        n_checks++; if (bus.preempcao !== 1'b0) begin n_fail++; $display("FAIL preempcao_pulse_width: got %b expected 0", bus.preempcao); end
        bus.retorno = 1; tick();
        n_checks++; if (bus.endereco !== 32'd200) begin n_fail++; $display("FAIL retorno_so: got %0d expected 200", bus.endereco); end
        dispatch(2);
        n_checks++; if (bus.endereco !== (PREEMPT ? 32'd404 : 32'd400)) begin
            n_fail++; $display("FAIL redispatch_2: got %0d expected %0d", bus.endereco, PREEMPT ? 404 : 400);
        end
        go_so();
    endtask

    task automatic test_expiry_branch();
        dispatch(3);
        n_checks++; if (bus.endereco !== 32'd600) begin n_fail++; $display("FAIL dispatch_3: got %0d expected 600", bus.endereco); end
        tick(); tick(); tick();
        bus.desvio = 1; bus.alvo = 32'd50; tick();
        if (PREEMPT) begin
            n_checks++; if (bus.endereco !== 32'd0 || bus.preempcao !== 1'b1) begin
                n_fail++; $display("FAIL expiry_branch: got %0d pre=%b expected 0 pre=1", bus.endereco, bus.preempcao);
            end
            bus.retorno = 1; tick();
            dispatch(3);
        end
        n_checks++; if (bus.endereco !== 32'd650) begin n_fail++; $display("FAIL resume_branch: got %0d expected 650", bus.endereco); end
        go_so();
    endtask

    task automatic test_halt_illegal();
        dispatch(5);
        tick();
        n_checks++; if (bus.endereco !== 32'd1001) begin n_fail++; $display("FAIL slot5_run: got %0d expected 1001", bus.endereco); end
        bus.halt_proc = 1; tick();
        n_checks++; if (bus.endereco !== 32'd0 || bus.slot_atual !== 4'd0) begin
            n_fail++; $display("FAIL halt: got %0d slot %0d expected 0 slot 0", bus.endereco, bus.slot_atual);
        end
        bus.retorno = 1; tick();
        dispatch(5);
        n_checks++; if (bus.endereco !== 32'd1000) begin n_fail++; $display("FAIL halt_restart: got %0d expected 1000", bus.endereco); end
        go_so();
        bus.troca_req = 1; bus.proc_sel = 4'd1; tick();
        n_checks++; if (bus.erro !== 1'b1 || bus.slot_atual !== 4'd1 || bus.em_usuario !== 1'b0) begin
            n_fail++; $display("FAIL illegal_sel1: got erro=%b slot=%0d expected erro=1 slot=1", bus.erro, bus.slot_atual);
        end
        n_checks++; if (bus.endereco !== 32'(exp_addr())) begin n_fail++; $display("FAIL illegal_sel1_step: got %0d expected %0d", bus.endereco, exp_addr()); end
        bus.troca_req = 1; bus.proc_sel = 4'd12; tick();
        n_checks++; if (bus.erro !== 1'b1 || bus.slot_atual !== 4'd1) begin
            n_fail++; $display("FAIL illegal_sel12: got erro=%b slot=%0d expected erro=1 slot=1", bus.erro, bus.slot_atual);
        end
        tick();
        n_checks++; if (bus.erro !== 1'b0) begin n_fail++; $display("FAIL erro_pulse_width: got %b expected 0", bus.erro); end
    endtask

    task automatic test_stall_target();
        logic [AW-1:0] held;
        dispatch(4);
        tick();
        held = bus.endereco;
        n_checks++; if (held !== 32'd801) begin n_fail++; $display("FAIL stall_pre: got %0d expected 801", held); end
        for (int k = 0; k < 3; k++) begin
            bus.stall = 1; bus.halt_proc = 1'($urandom); bus.desvio = 1'($urandom);
            bus.alvo = 32'($urandom_range(0, 199)); tick();
            n_checks++; if (bus.endereco !== held || bus.em_usuario !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold%0d: got %0d expected %0d", k, bus.endereco, held);
            end
        end
        tick(); tick(); tick();
        n_checks++; if (bus.endereco !== (PREEMPT ? 32'd0 : 32'd804) || bus.preempcao !== PREEMPT) begin
            n_fail++; $display("FAIL stall_counter: got %0d pre=%b expected %0d pre=%b", bus.endereco, bus.preempcao, PREEMPT ? 0 : 804, PREEMPT);
        end
        go_so();
        bus.desvio = 1; bus.alvo = 32'd250; tick();
        n_checks++; if (bus.endereco !== 32'd200 || bus.erro !== 1'b1) begin
            n_fail++; $display("FAIL illegal_target: got %0d erro=%b expected 200 erro=1", bus.endereco, bus.erro);
        end
        bus.desvio = 1; bus.alvo = 32'd199; tick();
        n_checks++; if (bus.endereco !== 32'd399 || bus.erro !== 1'b0) begin
            n_fail++; $display("FAIL legal_target: got %0d erro=%b expected 399 erro=0", bus.endereco, bus.erro);
        end
        tick();
        n_checks++; if (bus.endereco !== 32'd200) begin n_fail++; $display("FAIL branch_wrap: got %0d expected 200", bus.endereco); end
    endtask

    task automatic test_no_preempt();
        int pulses = 0;
        int left_user = 0;
        dispatch(6);
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (bus.preempcao) pulses++;
            if (!bus.em_usuario) left_user++;
        end
        n_checks++; if (pulses != 0 || left_user != 0) begin
            n_fail++; $display("FAIL no_preempt_1000: got pulses=%0d exits=%0d expected 0/0", pulses, left_user);
        end
        n_checks++; if (bus.endereco !== 32'(exp_addr())) begin n_fail++; $display("FAIL no_preempt_addr: got %0d expected %0d", bus.endereco, exp_addr()); end
        go_so();
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            bus.stall = ($urandom_range(0, 7) == 0);
            bus.desvio = ($urandom_range(0, 3) == 0);
            bus.alvo = 32'($urandom_range(0, SS - 1));
            if (m_slot < 2 && $urandom_range(0, 7) == 0) bus.alvo = 32'($urandom_range(SS, 400));
            bus.retorno = ($urandom_range(0, 3) == 0);
            bus.troca_req = ($urandom_range(0, 1) == 0);
            bus.proc_sel = 4'($urandom_range(0, 15));
            if (bus.troca_req && !(bus.proc_sel >= 2 && int'(bus.proc_sel) < NS)) bus.desvio = 0;
            bus.halt_proc = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++; if (bus.endereco !== 32'(exp_addr())) begin n_fail++; $display("FAIL rnd_endereco@%0d: got %0d expected %0d", k, bus.endereco, exp_addr()); end
            n_checks++; if (bus.slot_atual !== 4'(m_slot)) begin n_fail++; $display("FAIL rnd_slot@%0d: got %0d expected %0d", k, bus.slot_atual, m_slot); end
            n_checks++; if (bus.em_usuario !== (m_slot >= 2)) begin n_fail++; $display("FAIL rnd_em_usuario@%0d: got %b expected %b", k, bus.em_usuario, m_slot >= 2); end
            n_checks++; if (bus.preempcao !== m_pre) begin n_fail++; $display("FAIL rnd_preempcao@%0d: got %b expected %b", k, bus.preempcao, m_pre); end
            n_checks++; if (bus.erro !== m_err) begin n_fail++; $display("FAIL rnd_erro@%0d: got %b expected %b", k, bus.erro, m_err); end
        end
        go_so();
    endtask

    task automatic test_reset_midop();
        dispatch(7);
        repeat (4) tick();
        go_so();
        dispatch(7);
        #2 reset_n = 0;
        #1;
        n_checks++; if (bus.endereco !== 32'd200 || bus.slot_atual !== 4'd1 || bus.em_usuario !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %0d slot %0d usr %b expected 200 slot 1 usr 0", bus.endereco, bus.slot_atual, bus.em_usuario);
        end
        model_reset();
        #2 reset_n = 1;
        dispatch(7);
        n_checks++; if (bus.endereco !== 32'd1400) begin n_fail++; $display("FAIL table_cleared: got %0d expected 1400", bus.endereco); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_dispatch();
        test_expiry_branch();
        test_halt_illegal();
        test_stall_target();
        if (!PREEMPT) test_no_preempt();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
